// File: rtl/line_buffer.sv
// line_buffer: NUM_TAPS-row vertical line buffer with valid/ready handshake.
// Each output column holds the newest accepted sample in tap 0 and, in tap k,
// the sample accepted k*D accepts earlier. D is the configured row length.
// The delay rows are kept in NUM_TAPS-1 block-RAM-friendly memories that are
// chained: each memory's old contents feed the next memory in the same slot.
module line_buffer #(
  parameter int IMG_WIDTH  = 8,
  parameter int MEM_AWIDTH = 10,
  parameter int NUM_TAPS   = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [MEM_AWIDTH-1:0]         cfg_delay,
  input  logic                          cfg_set,
  input  logic [IMG_WIDTH-1:0]          up_data,
  input  logic                          up_val,
  output logic                          up_rdy,
  output logic [NUM_TAPS*IMG_WIDTH-1:0] dn_data,
  output logic                          dn_val,
  input  logic                          dn_rdy
);

  localparam int MEM_DEPTH = 1 << MEM_AWIDTH;
  // Wide enough for (NUM_TAPS-1) * MEM_DEPTH.
  localparam int CNT_W     = MEM_AWIDTH + $clog2(NUM_TAPS) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // A single-tap buffer needs no history, so configuring goes straight to RUN.
  localparam state_t CFG_STATE = (NUM_TAPS == 1) ? ST_RUN : ST_PRIME;

  state_t                               state_reg;
  state_t                               state_next;
  logic [MEM_AWIDTH-1:0]                delay_reg;
  logic [MEM_AWIDTH:0]                  delay_full;
  logic [MEM_AWIDTH-1:0]                delay_last;
  logic [MEM_AWIDTH-1:0]                ptr_reg;
  logic [MEM_AWIDTH-1:0]                ptr_next;
  logic [CNT_W-1:0]                     prime_cnt_reg;
  logic [CNT_W-1:0]                     prime_cnt_next;
  logic [CNT_W-1:0]                     prime_target;
  logic                                 acc;
  logic                                 out_free;
  logic [NUM_TAPS-1:0][IMG_WIDTH-1:0]   taps;
  logic                                 dn_val_reg;
  logic [NUM_TAPS*IMG_WIDTH-1:0]        dn_data_reg;

  // ---------------------------------------------------------------------------
  // Handshake and derived configuration values
  // ---------------------------------------------------------------------------

  // The output register can take a new column when empty or being drained.
  assign out_free = ~dn_val_reg | dn_rdy;
  // cfg_set blocks input so no sample is lost while the buffer restarts.
  assign up_rdy   = (state_reg != ST_IDLE) & ~cfg_set & out_free;
  assign acc      = up_val & up_rdy;

  // A stored delay of zero stands for a full-depth row.
  assign delay_full   = {(delay_reg == '0), delay_reg};
  // Last pointer slot; zero wraps naturally to MEM_DEPTH-1.
  assign delay_last   = delay_reg - MEM_AWIDTH'(1);
  // Accepts needed to fill every row memory before a column is complete.
  assign prime_target = CNT_W'(NUM_TAPS - 1) * CNT_W'(delay_full);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------

  // State register; reset returns to the unconfigured state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state: configure restarts priming, the final priming accept enters RUN.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  state_next = ST_IDLE;
      ST_PRIME: begin
        if (acc && (prime_cnt_next == prime_target)) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN:   state_next = ST_RUN;
      default:  state_next = ST_IDLE;
    endcase
    if (cfg_set) begin
      state_next = CFG_STATE;
    end
  end

  // ---------------------------------------------------------------------------
  // Configuration, pointer and priming counter
  // ---------------------------------------------------------------------------

  // Row length is captured only on the configuration strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      delay_reg <= '0;
    end else if (cfg_set) begin
      delay_reg <= cfg_delay;
    end
  end

  // Shared row pointer advances per accept and wraps after D slots.
  always_comb begin
    ptr_next = ptr_reg;
    if (cfg_set) begin
      ptr_next = '0;
    end else if (acc) begin
      ptr_next = (ptr_reg == delay_last) ? '0 : ptr_reg + MEM_AWIDTH'(1);
    end
  end

  // Priming counter counts accepts made while the rows are still filling.
  always_comb begin
    prime_cnt_next = prime_cnt_reg;
    if (cfg_set) begin
      prime_cnt_next = '0;
    end else if (acc && (state_reg == ST_PRIME)) begin
      prime_cnt_next = prime_cnt_reg + CNT_W'(1);
    end
  end

  // Pointer and priming count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg       <= '0;
      prime_cnt_reg <= '0;
    end else begin
      ptr_reg       <= ptr_next;
      prime_cnt_reg <= prime_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Row memories
  // ---------------------------------------------------------------------------
  // Each memory's registered read port is addressed with the pointer value
  // that will be current at the next accept, so the old slot contents are
  // already on the read register when that accept arrives. That lets the
  // chain use the read data combinationally as the next memory's write data
  // while keeping a pure synchronous-read RAM.

  assign taps[0] = up_data;

  for (genvar gi = 0; gi < NUM_TAPS - 1; gi++) begin : g_row
    logic [IMG_WIDTH-1:0] mem [MEM_DEPTH];
    logic [IMG_WIDTH-1:0] rd_reg;

    // Write the incoming tap at ptr; prefetch the next slot. With D=1 the
    // next slot is the one being written, so the new word is forwarded.
    always_ff @(posedge clk) begin
      if (acc) begin
        mem[ptr_reg] <= taps[gi];
      end
      if (acc && (ptr_next == ptr_reg)) begin
        rd_reg <= taps[gi];
      end else begin
        rd_reg <= mem[ptr_next];
      end
    end

    assign taps[gi + 1] = rd_reg;
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------

  // Capture a column per accept in RUN; hold while stalled; drop on reconfigure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dn_val_reg  <= 1'b0;
      dn_data_reg <= '0;
    end else if (cfg_set) begin
      dn_val_reg  <= 1'b0;
    end else if (acc && (state_reg == ST_RUN)) begin
      dn_val_reg  <= 1'b1;
      dn_data_reg <= taps;
    end else if (dn_rdy) begin
      dn_val_reg  <= 1'b0;
    end
  end

  assign dn_val  = dn_val_reg;
  assign dn_data = dn_data_reg;

endmodule

// File: tb/tb_line_buffer.sv
// tb_line_buffer: randomized scoreboard bench for line_buffer.
// Three instances (3, 2 and 1 taps) share clock and reset. Per instance, a
// model process keeps the history of accepted samples and pushes the column
// each run-mode accept should produce; a monitor pops and compares on every
// output transfer.
module tb_line_buffer;

  localparam int W  = 8;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    cfg_set;
  logic [AW-1:0] cfg_delay [3];
  logic [W-1:0]  up_data   [3];
  logic [2:0]    up_val;
  logic [2:0]    up_rdy;
  logic [2:0]    dn_val;
  logic [2:0]    dn_rdy;
  logic [23:0]   dn_col    [3];
  logic [23:0]   dn_d3;
  logic [15:0]   dn_d2;
  logic [7:0]    dn_d1;

  int            total = 0;
  int            bad   = 0;
  int unsigned   ramp_ctr = 0;

  always #5 clk = ~clk;

  line_buffer #(.IMG_WIDTH(W), .MEM_AWIDTH(AW), .NUM_TAPS(3)) u_dut3 (
    .clk(clk), .rst(rst), .cfg_delay(cfg_delay[0]), .cfg_set(cfg_set[0]),
    .up_data(up_data[0]), .up_val(up_val[0]), .up_rdy(up_rdy[0]),
    .dn_data(dn_d3), .dn_val(dn_val[0]), .dn_rdy(dn_rdy[0])
  );

  line_buffer #(.IMG_WIDTH(W), .MEM_AWIDTH(AW), .NUM_TAPS(2)) u_dut2 (
    .clk(clk), .rst(rst), .cfg_delay(cfg_delay[1]), .cfg_set(cfg_set[1]),
    .up_data(up_data[1]), .up_val(up_val[1]), .up_rdy(up_rdy[1]),
    .dn_data(dn_d2), .dn_val(dn_val[1]), .dn_rdy(dn_rdy[1])
  );

  line_buffer #(.IMG_WIDTH(W), .MEM_AWIDTH(AW), .NUM_TAPS(1)) u_dut1 (
    .clk(clk), .rst(rst), .cfg_delay(cfg_delay[2]), .cfg_set(cfg_set[2]),
    .up_data(up_data[2]), .up_val(up_val[2]), .up_rdy(up_rdy[2]),
    .dn_data(dn_d1), .dn_val(dn_val[2]), .dn_rdy(dn_rdy[2])
  );

  assign dn_col[0] = dn_d3;
  assign dn_col[1] = {8'h00, dn_d2};
  assign dn_col[2] = {16'h0000, dn_d1};

  task automatic check(input string name, input int inst,
                       input logic [23:0] act, input logic [23:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d t=%0t: got=%h want=%h", name, inst, $time, act, exp);
    end
  endtask

  // Per-instance reference model and monitor.
  for (genvar gi = 0; gi < 3; gi++) begin : g_chk
    localparam int NT = 3 - gi;
    logic [7:0]  hist [$];
    logic [23:0] expq [$];
    int          d = 1;
    bit          cfgd = 1'b0;
    bit          exp_val = 1'b0;
    bit          exp_rdy;
    bit          acc;
    bit          stall = 1'b0;
    logic [23:0] col;
    logic [23:0] col_m;
    logic [23:0] held;
    int          nout = 0;

    // Model: predicts handshake signals and pushes the expected columns.
    always @(negedge clk) begin
      if (!rst) begin
        cfgd    = 1'b0;
        exp_val = 1'b0;
        hist.delete();
        expq.delete();
      end else begin
        check("dn_val", gi, 24'(dn_val[gi]), 24'(exp_val));
        exp_rdy = cfgd && !cfg_set[gi] && (!exp_val || dn_rdy[gi]);
        check("up_rdy", gi, 24'(up_rdy[gi]), 24'(exp_rdy));
        acc = up_val[gi] && exp_rdy;
        if (cfg_set[gi]) begin
          if (exp_val && !dn_rdy[gi] && expq.size() > 0) void'(expq.pop_front());
          d       = (cfg_delay[gi] == 0) ? (1 << AW) : int'(cfg_delay[gi]);
          cfgd    = 1'b1;
          exp_val = 1'b0;
          hist.delete();
        end else if (acc) begin
          hist.push_back(up_data[gi]);
          if (hist.size() > (NT - 1) * d) begin
            col = '0;
            for (int k = 0; k < NT; k++) col[k*8 +: 8] = hist[hist.size() - 1 - k*d];
            expq.push_back(col);
            exp_val = 1'b1;
          end else if (dn_rdy[gi]) begin
            exp_val = 1'b0;
          end
        end else if (dn_rdy[gi]) begin
          exp_val = 1'b0;
        end
        if (hist.size() > 4096) void'(hist.pop_front());
      end
    end

    // Monitor: compares each transferred column and stability under stall.
    always @(negedge clk) begin
      if (!rst) begin
        stall = 1'b0;
      end else begin
        if (stall && dn_val[gi]) check("hold", gi, dn_col[gi], held);
        if (dn_val[gi] && dn_rdy[gi]) begin
          nout++;
          if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_out inst%0d t=%0t: got col=%h want no output", gi, $time, dn_col[gi]);
          end else begin
            col_m = expq.pop_front();
            $display("inst%0d out%0d col=%h exp=%h", gi, nout, dn_col[gi], col_m);
            check("col", gi, dn_col[gi], col_m);
          end
        end
        stall = dn_val[gi] && !dn_rdy[gi];
        held  = dn_col[gi];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int i, input int dv);
    cfg_delay[i] = AW'(dv);
    cfg_set[i]   = 1'b1;
    step();
    cfg_set[i]   = 1'b0;
  endtask

  // Drive one instance for a number of cycles with given valid/ready odds.
  task automatic run(input int i, input int cycles, input int vp, input int rp, input bit ramp);
    bit took;
    for (int c = 0; c < cycles; c++) begin
      up_val[i]  = ($urandom_range(99) < vp);
      dn_rdy[i]  = ($urandom_range(99) < rp);
      up_data[i] = ramp ? 8'(ramp_ctr) : 8'($urandom);
      @(negedge clk);
      took = up_val[i] && up_rdy[i];
      @(posedge clk);
      #1;
      if (ramp && took) ramp_ctr++;
    end
  endtask

  initial begin
    rst     = 1'b0;
    cfg_set = '0;
    up_val  = '0;
    dn_rdy  = '0;
    for (int i = 0; i < 3; i++) begin
      cfg_delay[i] = '0;
      up_data[i]   = '0;
    end
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      check("rst_dn_val", i, 24'(dn_val[i]), 24'd0);
      check("rst_up_rdy", i, 24'(up_rdy[i]), 24'd0);
      check("rst_dn_data", i, dn_col[i], 24'd0);
    end
    rst = 1'b1;
    step();

    // Unconfigured: valid held high must not be accepted.
    run(0, 10, 100, 100, 1'b1);

    // Basic 3-tap stream, D=4, full throughput.
    cfg(0, 4);
    run(0, 60, 100, 100, 1'b1);

    // Random backpressure.
    run(0, 300, 100, 50, 1'b1);

    // Reconfigure mid-stream to D=2 with valid held.
    up_val[0] = 1'b1;
    cfg(0, 2);
    run(0, 40, 100, 100, 1'b1);
    run(0, 100, 70, 60, 1'b1);

    // Asynchronous reset while an output is pending.
    dn_rdy[0] = 1'b0;
    up_val[0] = 1'b1;
    step();
    step();
    check("pre_rst_dn_val", 0, 24'(dn_val[0]), 24'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_dn_val", 0, 24'(dn_val[0]), 24'd0);
    check("async_rst_up_rdy", 0, 24'(up_rdy[0]), 24'd0);
    step();
    rst = 1'b1;
    run(0, 10, 100, 100, 1'b1);
    up_val[0] = 1'b0;

    // Full-depth rows (D=1024) on the 2-tap build.
    cfg(1, 0);
    run(1, 1100, 100, 100, 1'b0);
    run(1, 200, 80, 70, 1'b0);
    up_val[1] = 1'b0;

    // Single-tap pass-through.
    cfg(2, 5);
    run(2, 300, 60, 60, 1'b0);
    up_val[2] = 1'b0;
    dn_rdy    = '1;
    repeat (4) step();

    check("nout_min", 0, 24'(g_chk[0].nout >= 100), 24'd1);
    check("nout_min", 1, 24'(g_chk[1].nout >= 100), 24'd1);
    check("nout_min", 2, 24'(g_chk[2].nout >= 60), 24'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
